rx_frame_ctrl: RTL and testbench



---
 rtl/rx_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: start/bit/stop sequencing for an LSB-first serial-to-parallel receiver.
// Define RX_PARITY_CHECK_EN to add an even-parity bit between the data and stop bits.
module rx_frame_ctrl #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
`ifdef RX_PARITY_CHECK_EN
  output logic parity_error,
`endif
  output logic busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_CHECK_EN
    PARITY,
`endif
    STOP,
    LOAD
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic          stop_ok, stop_ok_nx;
  logic          s1, s2, s_prev;
  logic          start_det;
  logic          bit_end;
`ifdef RX_PARITY_CHECK_EN
  logic          par_acc, par_acc_nx;
  logic          parity_nx;
`endif

  // Synchronizers idle high so a reset never fabricates a falling edge on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s1     <= serial_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign start_det = (state == IDLE) && s_prev && !s2;
  assign bit_end   = (timer == T_LAST);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    bit_cnt_nx   = bit_cnt;
    stop_ok_nx   = stop_ok;
    shift_enable = 1'b0;
    load_buffer  = 1'b0;
`ifdef RX_PARITY_CHECK_EN
    par_acc_nx   = par_acc;
    parity_nx    = parity_error;
`endif
    case (state)
      IDLE: begin
        if (start_det) begin
          state_nx   = START;
          timer_nx   = '0;
          bit_cnt_nx = '0;
`ifdef RX_PARITY_CHECK_EN
          par_acc_nx = 1'b0;
          parity_nx  = 1'b0;
`endif
        end
      end
      START: begin
        if (timer == T_HALF) begin
          timer_nx = '0;
          state_nx = s2 ? IDLE : DATA;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_enable = 1'b1;
          timer_nx     = '0;
`ifdef RX_PARITY_CHECK_EN
          par_acc_nx   = par_acc ^ s2;
`endif
          if (bit_cnt == B_LAST) begin
            bit_cnt_nx = '0;
`ifdef RX_PARITY_CHECK_EN
            state_nx   = PARITY;
`else
            state_nx   = STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
`ifdef RX_PARITY_CHECK_EN
      PARITY: begin
        if (bit_end) begin
          timer_nx  = '0;
          parity_nx = par_acc ^ s2;
          state_nx  = STOP;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          timer_nx   = '0;
          stop_ok_nx = s2;
          state_nx   = LOAD;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      LOAD: begin
`ifdef RX_PARITY_CHECK_EN
        load_buffer = stop_ok && !parity_error;
`else
        load_buffer = stop_ok;
`endif
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      stop_ok       <= 1'b0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
      par_acc       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_cnt <= bit_cnt_nx;
      stop_ok <= stop_ok_nx;
`ifdef RX_PARITY_CHECK_EN
      par_acc      <= par_acc_nx;
      parity_error <= parity_nx;
`endif
      // A load coinciding with data_read wins and is not an overrun.
      if (load_buffer) begin
        data_ready <= 1'b1;
        if (data_ready && !data_read) overrun_error <= 1'b1;
        else if (data_read)           overrun_error <= 1'b0;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (start_det)                      framing_error <= 1'b0;
      else if (state == LOAD && !stop_ok) framing_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: frame table, hand-written corner sequences, and random
// line activity checked every cycle against a bit-period timeline model.
`timescale 1ns/1ps
module tb_rx_frame_ctrl;

  localparam int N = 8;
  localparam int C = 10;
  localparam int H = C / 2;
`ifdef RX_PARITY_CHECK_EN
  localparam int FB = N + 1;
`else
  localparam int FB = N;
`endif
  localparam int FRAME_LEN = (FB + 2) * C;
  // Line cycle (counting the first low cycle as 0) in which the controller sits in LOAD.
  localparam int LOAD_IDX = 4 + H + (FB + 1) * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic data_read = 1'b0;
  logic shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy;
`ifdef RX_PARITY_CHECK_EN
  logic parity_error;
`endif

  int checks = 0;
  int errors = 0;
  int n_shift = 0;
  int n_load = 0;
  int cyc = 0;
  bit saw_busy = 0;
  bit saw_coinc = 0;
  bit started = 0;
  int pulse_q[$];

  rx_frame_ctrl #(.NUM_BITS(N), .CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .data_read(data_read),
    .shift_enable(shift_enable),
    .load_buffer(load_buffer),
    .data_ready(data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
`ifdef RX_PARITY_CHECK_EN
    .parity_error(parity_error),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: "age" counts cycles since the controller became busy; all
  // events follow from the start-bit half period plus whole bit periods.
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_sp = 1'b1;
  logic m_active = 1'b0, m_stop_ok = 1'b0, m_pe = 1'b0, m_xr = 1'b0;
  logic m_dr = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  int   m_age = 0;

  function automatic logic m_shift();
    int k = m_age - (H + 1);
    return m_active && m_age > H && k < N * C && (k % C) == C - 1;
  endfunction

  function automatic logic m_load_cycle();
    return m_active && m_age > H && (m_age - (H + 1)) == (FB + 1) * C;
  endfunction

  always @(posedge clk) begin : model
    int k;
    logic sh, lc, ld, det;
    k   = m_age - (H + 1);
    sh  = m_shift();
    lc  = m_load_cycle();
    ld  = lc && m_stop_ok && !m_pe;
    det = !m_active && m_sp && !m_s2;
    started = 1;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_sp = 1;
      m_active = 0; m_age = 0; m_stop_ok = 0; m_pe = 0; m_xr = 0;
      m_dr = 0; m_fe = 0; m_ov = 0;
    end else begin
      if (ld) begin
        if (m_dr && !data_read) m_ov = 1;
        else if (data_read)     m_ov = 0;
        m_dr = 1;
      end else if (data_read) begin
        m_dr = 0; m_ov = 0;
      end
      if (lc && !m_stop_ok) m_fe = 1;
      if (m_active) begin
        if (m_age == H && m_s2) m_active = 0;
        else if (m_age > H) begin
          if (sh) m_xr = m_xr ^ m_s2;
          if (FB > N && k == N * C + C - 1) m_pe = m_xr ^ m_s2;
          if (k == FB * C + C - 1) m_stop_ok = m_s2;
          if (lc) m_active = 0;
        end
        m_age++;
      end else if (det) begin
        m_active = 1; m_age = 0; m_fe = 0; m_pe = 0; m_xr = 0;
      end
      m_sp = m_s2; m_s2 = m_s1; m_s1 = serial_in;
    end
  end

  always @(negedge clk) begin : monitor
    logic [6:0] got, ex;
    if (started) begin
      cyc++;
      ex  = {m_pe, m_shift(), m_load_cycle() && m_stop_ok && !m_pe, m_dr, m_fe, m_ov, m_active};
`ifdef RX_PARITY_CHECK_EN
      got = {parity_error, shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy};
`else
      got = {1'b0, shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy};
      ex[6] = 1'b0;
`endif
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL cycle_model cyc=%0d {par,shift,load,rdy,ferr,ovr,busy} got=%b expected=%b",
                 cyc, got, ex);
      end
      if (shift_enable === 1'b1) begin n_shift++; pulse_q.push_back(cyc); end
      if (load_buffer === 1'b1) n_load++;
      if (busy === 1'b1) saw_busy = 1;
      if (load_buffer === 1'b1 && data_read) saw_coinc = 1;
    end
  end

  task automatic check(input string name, input int got, input int ex);
    checks++;
    if (got != ex) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, ex);
    end
  endtask

  task automatic tick(input logic s, input logic rd);
    serial_in = s;
    data_read = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic rtick(input logic s);
    rst = ($urandom_range(0, 1999) == 0);
    tick(s, $urandom_range(0, 7) == 0);
    rst = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [15:0] d, input logic stop,
                                     input logic bad_par, input int idx);
    int b = idx / C;
    logic p = bad_par;
    if (b == 0) return 1'b0;
    if (b <= N) return d[b-1];
    if (b == FB + 1) return stop;
    for (int i = 0; i < N; i++) p = p ^ d[i];
    return p;
  endfunction

  task automatic send_frame(input logic [15:0] d, input logic stop, input int rd_idx);
    for (int i = 0; i < FRAME_LEN; i++) tick(frame_bit(d, stop, 1'b0, i), i == rd_idx);
  endtask

  typedef struct {
    logic [15:0] data;
    logic        stop;
    logic        rd_after;
    int          exp_shift;
    int          exp_load;
    logic [2:0]  exp_flags; // {data_ready, framing_error, overrun_error}
  } vec_t;

  vec_t tbl[6];

  initial begin
    int bad;
    tbl[0] = '{16'h00A5, 1'b1, 1'b0, 8, 1, 3'b100};
    tbl[1] = '{16'h003C, 1'b0, 1'b0, 8, 0, 3'b110};
    tbl[2] = '{16'h00FF, 1'b1, 1'b0, 8, 1, 3'b101};
    tbl[3] = '{16'h0000, 1'b1, 1'b1, 8, 1, 3'b000};
    tbl[4] = '{16'h0081, 1'b1, 1'b0, 8, 1, 3'b100};
    tbl[5] = '{16'h005A, 1'b0, 1'b1, 8, 0, 3'b010};

    rst = 1'b1;
    tick(1, 0);
    tick(1, 0);
    check("reset_outputs",
          int'({shift_enable, load_buffer, data_ready, framing_error, overrun_error, busy}), 0);
    rst = 1'b0;
    repeat (3) tick(1, 0);

    for (int i = 0; i < 6; i++) begin
      n_shift = 0; n_load = 0; pulse_q.delete();
      send_frame(tbl[i].data, tbl[i].stop, -1);
      repeat (3) tick(1, 0);
      if (tbl[i].rd_after) tick(1, 1);
      tick(1, 0);
      check($sformatf("vec%0d_shifts", i), n_shift, tbl[i].exp_shift);
      check($sformatf("vec%0d_loads", i), n_load, tbl[i].exp_load);
      check($sformatf("vec%0d_flags", i), int'({data_ready, framing_error, overrun_error}),
            int'(tbl[i].exp_flags));
      if (i == 0) begin
        bad = 0;
        for (int j = 1; j < pulse_q.size(); j++) if (pulse_q[j] - pulse_q[j-1] != C) bad++;
        check("vec0_pulse_spacing", bad, 0);
      end
    end

    // Read acknowledge landing in the LOAD cycle of a second unread frame.
    send_frame(16'h0066, 1'b1, -1);
    repeat (3) tick(1, 0);
    n_load = 0; saw_coinc = 0;
    send_frame(16'h0099, 1'b1, LOAD_IDX);
    tick(1, 0);
    check("coinc_load", n_load, 1);
    check("coinc_read_in_load", int'(saw_coinc), 1);
    check("coinc_flags", int'({data_ready, framing_error, overrun_error}), 3'b100);
    tick(1, 1);
    tick(1, 0);

    n_shift = 0; n_load = 0; saw_busy = 0;
    repeat (3) tick(0, 0);
    repeat (20) tick(1, 0);
    check("false_start_shifts", n_shift, 0);
    check("false_start_loads", n_load, 0);
    check("false_start_saw_busy", int'(saw_busy), 1);
    check("false_start_busy_end", int'(busy), 0);

    repeat (C) tick(0, 0);
    repeat (3 * C) tick(1, 0);
    check("middata_busy", int'(busy), 1);
    rst = 1'b1;
    tick(1, 0);
    rst = 1'b0;
    check("middata_rst_busy", int'(busy), 0);
    n_shift = 0;
    repeat (4 * C) tick(1, 0);
    check("middata_rst_no_shift", n_shift, 0);

    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 9) < 2) begin
        repeat ($urandom_range(1, 4)) rtick(1'b0);
      end else begin
        logic [15:0] d;
        logic stop, bp;
        d    = 16'($urandom);
        stop = ($urandom_range(0, 4) != 0);
        bp   = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < FRAME_LEN; i++) rtick(frame_bit(d, stop, bp, i));
      end
      repeat ($urandom_range(0, 12)) rtick(1'b1);
    end
    repeat (5) tick(1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
